// File: rtl/intersection_pkg.sv
// Shared types and defaults for the two-street intersection traffic model.
// Optional feature macro: INTERSECTION_STATS_EN (per-lane departure counters).
package intersection_pkg;

    localparam int unsigned QMAX_DEF    = 15;
    localparam int unsigned HEADWAY_DEF = 2;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned TMR_W       = 3;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    typedef enum logic [0:0] {
        LANE_STOP = 1'b0,
        LANE_GO   = 1'b1
    } lane_state_t;

    // 2'b10 and the unused code 2'b11 both count as red, so bit 1 alone decides.
    function automatic logic light_is_red(input logic [1:0] l);
        return l[1];
    endfunction

endpackage

// File: rtl/lane_queue.sv
// One street's car queue: STOP/GO FSM, headway timer, saturating occupancy
// counter and arrival-drop detection.
module lane_queue
    import intersection_pkg::*;
#(
    parameter int unsigned QMAX    = QMAX_DEF,
    parameter int unsigned HEADWAY = HEADWAY_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             arr_i,
    input  logic [1:0]       light_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             depart_o,
    output logic             drop_o
);

    localparam logic [0:0]       S_STOP   = LANE_STOP;
    localparam logic [0:0]       S_GO     = LANE_GO;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HEADWAY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(QMAX);

    logic [0:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             green;
    logic [TMR_W-1:0] timer_cur;
    logic             depart;
    logic             full;

    // Next-state, headway timer and queue count for the current cycle.
    // The timer value seen in the first GREEN cycle is the STOP->GO load value,
    // so that cycle already counts toward the headway.
    always_comb begin
        green     = (light_i == GREEN);
        state_d   = green ? S_GO : S_STOP;
        timer_cur = (state_q == S_STOP) ? TMR_LOAD : timer_q;
        depart    = green && (timer_cur == '0) && (cnt_q != '0);
        full      = (cnt_q == CNT_MAX);

        timer_d = timer_cur;
        if (!green) begin
            timer_d = TMR_LOAD;
        end else if (depart) begin
            timer_d = TMR_LOAD;
        end else if (timer_cur != '0) begin
            timer_d = timer_cur - 1'b1;
        end

        cnt_d  = cnt_q;
        drop_o = 1'b0;
        if (arr_i && !depart) begin
            if (full) begin
                drop_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (depart && !arr_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Lane state registers; reset empties the queue immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_STOP;
            timer_q <= TMR_LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign depart_o = depart;

endmodule

// File: rtl/intersection_model.sv
// Two-street intersection traffic model: two lane queues, traffic sensors,
// sticky overflow and light-conflict flags.
// Optional feature macro: INTERSECTION_STATS_EN adds served_a/served_b.
module intersection_model
    import intersection_pkg::*;
#(
    parameter int unsigned QMAX    = QMAX_DEF,
    parameter int unsigned HEADWAY = HEADWAY_DEF
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             arr_a,
    input  logic             arr_b,
    input  logic [1:0]       la,
    input  logic [1:0]       lb,
    output logic             ta,
    output logic             tb,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             ovf,
    output logic             conflict
`ifdef INTERSECTION_STATS_EN
    ,
    output logic [7:0]       served_a,
    output logic [7:0]       served_b
`endif
);

    logic dep_a, dep_b;
    logic drop_a, drop_b;
    logic ovf_q, ovf_d;
    logic conflict_q, conflict_d;

    lane_queue #(
        .QMAX    (QMAX),
        .HEADWAY (HEADWAY)
    ) u_lane_a (
        .clk_i    (clk),
        .rst_ni   (reset_b),
        .arr_i    (arr_a),
        .light_i  (la),
        .cnt_o    (cnt_a),
        .depart_o (dep_a),
        .drop_o   (drop_a)
    );

    lane_queue #(
        .QMAX    (QMAX),
        .HEADWAY (HEADWAY)
    ) u_lane_b (
        .clk_i    (clk),
        .rst_ni   (reset_b),
        .arr_i    (arr_b),
        .light_i  (lb),
        .cnt_o    (cnt_b),
        .depart_o (dep_b),
        .drop_o   (drop_b)
    );

    // Sticky flags accumulate any dropped arrival or simultaneous non-red lights.
    always_comb begin
        ovf_d      = ovf_q | drop_a | drop_b;
        conflict_d = conflict_q | (!light_is_red(la) && !light_is_red(lb));
    end

    // Sticky flag registers, cleared only by reset.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ovf_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            ovf_q      <= ovf_d;
            conflict_q <= conflict_d;
        end
    end

    assign ta       = (cnt_a != '0);
    assign tb       = (cnt_b != '0);
    assign ovf      = ovf_q;
    assign conflict = conflict_q;

`ifdef INTERSECTION_STATS_EN
    logic [7:0] served_a_q, served_b_q;

    // Per-lane departure counters, free-running modulo 256.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            served_a_q <= '0;
            served_b_q <= '0;
        end else begin
            if (dep_a) served_a_q <= served_a_q + 8'd1;
            if (dep_b) served_b_q <= served_b_q + 8'd1;
        end
    end

    assign served_a = served_a_q;
    assign served_b = served_b_q;
`else
    logic unused_dep;
    assign unused_dep = dep_a ^ dep_b;
`endif

endmodule

// File: tb/tb_intersection_model.sv
// Directed, table-driven bench for intersection_model (HEADWAY=2 main
// instance plus a HEADWAY=1 instance for back-to-back departures).
module tb_intersection_model;

    logic       clk = 1'b0;
    logic       reset_b;
    logic       arr_a, arr_b;
    logic [1:0] la, lb;
    logic       ta, tb;
    logic [3:0] cnt_a, cnt_b;
    logic       ovf, conflict;

    logic       h_arr_a, h_arr_b;
    logic [1:0] h_la, h_lb;
    logic       h_ta, h_tb;
    logic [3:0] h_cnt_a, h_cnt_b;
    logic       h_ovf, h_conflict;

`ifdef INTERSECTION_STATS_EN
    logic [7:0] served_a, served_b, h_served_a, h_served_b;
`endif

    localparam logic [1:0] LG = 2'b00, LY = 2'b01, LR = 2'b10, LX = 2'b11;

    always #5 clk = ~clk;

    intersection_model #(.QMAX(15), .HEADWAY(2)) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .arr_a    (arr_a),
        .arr_b    (arr_b),
        .la       (la),
        .lb       (lb),
        .ta       (ta),
        .tb       (tb),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .ovf      (ovf),
        .conflict (conflict)
`ifdef INTERSECTION_STATS_EN
        ,
        .served_a (served_a),
        .served_b (served_b)
`endif
    );

    intersection_model #(.QMAX(15), .HEADWAY(1)) dut_h1 (
        .clk      (clk),
        .reset_b  (reset_b),
        .arr_a    (h_arr_a),
        .arr_b    (h_arr_b),
        .la       (h_la),
        .lb       (h_lb),
        .ta       (h_ta),
        .tb       (h_tb),
        .cnt_a    (h_cnt_a),
        .cnt_b    (h_cnt_b),
        .ovf      (h_ovf),
        .conflict (h_conflict)
`ifdef INTERSECTION_STATS_EN
        ,
        .served_a (h_served_a),
        .served_b (h_served_b)
`endif
    );

    typedef struct {
        logic [1:0] la;
        logic [1:0] lb;
        logic       arr_a;
        logic       arr_b;
        int         ca;
        int         cb;
        logic       ta;
        logic       tb;
        logic       ovf;
        logic       cfl;
    } vec_t;

    vec_t vt[15];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // la, lb, arr_a, arr_b, cnt_a, cnt_b, ta, tb, ovf, conflict
        vt[0]  = '{LR, LR, 1'b1, 1'b1, 1, 1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{LR, LR, 1'b1, 1'b1, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{LR, LR, 1'b1, 1'b0, 3, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{LG, LR, 1'b0, 1'b0, 3, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{LG, LR, 1'b0, 1'b0, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{LG, LR, 1'b0, 1'b0, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{LG, LR, 1'b0, 1'b0, 1, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{LG, LR, 1'b0, 1'b0, 1, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{LG, LR, 1'b0, 1'b0, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{LG, LR, 1'b0, 1'b0, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[10] = '{LG, LR, 1'b0, 1'b0, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[11] = '{LG, LR, 1'b1, 1'b0, 1, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[12] = '{LG, LR, 1'b0, 1'b0, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[13] = '{LY, LR, 1'b1, 1'b0, 1, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[14] = '{LX, LR, 1'b0, 1'b0, 1, 2, 1'b1, 1'b1, 1'b0, 1'b0};

        reset_b = 1'b0;
        arr_a = 1'b0; arr_b = 1'b0; la = LR; lb = LR;
        h_arr_a = 1'b0; h_arr_b = 1'b0; h_la = LR; h_lb = LR;
        repeat (2) tick();

        chk("reset cnt_a", cnt_a, 0);
        chk("reset cnt_b", cnt_b, 0);
        chk("reset ta", ta, 0);
        chk("reset tb", tb, 0);
        chk("reset ovf", ovf, 0);
        chk("reset conflict", conflict, 0);
        reset_b = 1'b1;

        // Main table: fill, drain at headway 2, arrival+departure, yellow and 2'b11 hold.
        for (int i = 0; i < 15; i++) begin
            la = vt[i].la; lb = vt[i].lb; arr_a = vt[i].arr_a; arr_b = vt[i].arr_b;
            tick();
            chk($sformatf("vec%0d cnt_a", i), cnt_a, vt[i].ca);
            chk($sformatf("vec%0d cnt_b", i), cnt_b, vt[i].cb);
            chk($sformatf("vec%0d ta", i), ta, vt[i].ta);
            chk($sformatf("vec%0d tb", i), tb, vt[i].tb);
            chk($sformatf("vec%0d ovf", i), ovf, vt[i].ovf);
            chk($sformatf("vec%0d conflict", i), conflict, vt[i].cfl);
        end

        // Fill lane B to QMAX, then one more arrival is dropped.
        la = LX; arr_a = 1'b0; lb = LR; arr_b = 1'b1;
        repeat (13) tick();
        chk("fill cnt_b", cnt_b, 15);
        chk("fill ovf", ovf, 0);
        tick();
        chk("drop cnt_b", cnt_b, 15);
        chk("drop ovf", ovf, 1);
        arr_b = 1'b0;
        tick();
        chk("ovf sticky", ovf, 1);
        chk("ovf cnt_b hold", cnt_b, 15);
        chk("la=11 no depart cnt_a", cnt_a, 1);

        // Yellow on A with green on B for one cycle.
        la = LY; lb = LG;
        tick();
        chk("conflict set", conflict, 1);
        la = LR; lb = LR;
        tick();
        chk("conflict sticky", conflict, 1);

        // Asynchronous reset mid-run with arrivals held.
        arr_a = 1'b1;
        #2;
        reset_b = 1'b0;
        #1;
        chk("async rst cnt_a", cnt_a, 0);
        chk("async rst cnt_b", cnt_b, 0);
        chk("async rst ta", ta, 0);
        chk("async rst ovf", ovf, 0);
        chk("async rst conflict", conflict, 0);
        tick();
        chk("in rst cnt_a", cnt_a, 0);
        chk("in rst ta", ta, 0);
        reset_b = 1'b1;
        tick();
        chk("post rst cnt_a 1", cnt_a, 1);
        chk("post rst ta", ta, 1);
        tick();
        chk("post rst cnt_a 2", cnt_a, 2);
        tick();
        chk("post rst cnt_a 3", cnt_a, 3);

        // Only one street non-red (2'b11 counts as red): no conflict.
        arr_a = 1'b0; la = LR; lb = LG;
        repeat (3) tick();
        chk("A red B green conflict", conflict, 0);
        la = LX;
        repeat (2) tick();
        chk("A 11 B green conflict", conflict, 0);
        la = LG; lb = LX;
        tick();
        chk("A green B 11 conflict", conflict, 0);
        chk("first green no depart", cnt_a, 3);
        la = LR;

        // HEADWAY=1 instance: departure every green cycle balances arrivals.
        h_arr_a = 1'b1; h_la = LR;
        repeat (5) tick();
        chk("h1 fill cnt_a", h_cnt_a, 5);
        h_la = LG;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("h1 hold%0d cnt_a", i), h_cnt_a, 5);
        end
        h_arr_a = 1'b0;
        tick();
        chk("h1 drain cnt_a 4", h_cnt_a, 4);
        tick();
        chk("h1 drain cnt_a 3", h_cnt_a, 3);
        chk("h1 ovf", h_ovf, 0);

`ifdef INTERSECTION_STATS_EN
        h_la = LR;
        reset_b = 1'b0;
        tick();
        chk("stats reset served_a", served_a, 0);
        reset_b = 1'b1;
        la = LG; lb = LR; arr_a = 1'b1;
        repeat (2) tick();
        chk("served_a first", served_a, 1);
        repeat (510) tick();
        chk("served_a wrap", served_a, 0);
        chk("served_b idle", served_b, 0);
        arr_a = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intersection_model.md
INTERSECTION_MODEL -- requirements
Module: intersection_model

Interface
REQ-001 Parameter QMAX, 15, maximum cars held per lane queue (counter width 4 bits).
REQ-002 Parameter HEADWAY, 2, clock cycles between successive departures on a green lane (range 1..7).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset_b  input  1  asynchronous, active-low reset.
REQ-005 Port arr_a, arr_b  input  1 each  car-arrival pulse for street A / B; one car per cycle high.
REQ-006 Port la, lb  input  2 each  light state for street A / B, driven by the traffic-light controller.
REQ-007 Port ta, tb  output  1 each  traffic-present sensor for street A / B, fed back to the controller.
REQ-008 Port cnt_a, cnt_b  output  4 each  current queue occupancy.
REQ-009 Port ovf  output  1  sticky: an arrival was dropped on a full queue.
REQ-010 Port conflict  output  1  sticky: both lights were non-red in the same cycle.

Function
REQ-011 Light encoding SHALL be GREEN=2'b00, YELLOW=2'b01, RED=2'b10; 2'b11 SHALL be treated as RED.
REQ-012 Each lane SHALL run a 2-state FSM: STOP (light not GREEN) and GO (light GREEN), evaluated every cycle.
REQ-013 On STOP->GO entry, the headway timer SHALL load HEADWAY-1; the first departure occurs HEADWAY cycles after the first GREEN cycle.
REQ-014 In GO, when the timer is 0 and count>0, one car SHALL depart (count-1) and the timer SHALL reload HEADWAY-1; otherwise the timer decrements, saturating at 0.
REQ-015 In STOP (including YELLOW), no departures SHALL occur and the timer SHALL hold at HEADWAY-1.
REQ-016 Arrival and departure in the same cycle SHALL leave count unchanged.
REQ-017 Arrival with count==QMAX and no same-cycle departure SHALL be dropped, count held, ovf set.
REQ-018 Departure with count==0 SHALL NOT occur; count never wraps below 0.
REQ-019 ta SHALL equal (cnt_a != 0) and tb SHALL equal (cnt_b != 0), decoded combinationally from registered counts (one-cycle lag from arrival).
REQ-020 conflict SHALL be set on the clock edge following any cycle where la and lb are both not RED (per REQ-011).
REQ-021 ovf and conflict SHALL remain set until reset.

Reset
REQ-022 While reset_b is low: cnt_a=cnt_b=0, ta=tb=0, ovf=0, conflict=0, both FSMs in STOP, timers = HEADWAY-1.
REQ-023 Reset asserted mid-operation SHALL discard queued cars immediately, without waiting for a clock edge.
REQ-024 Arrivals in the first edge after reset_b rises SHALL be counted normally.

Configuration
REQ-025 Macro INTERSECTION_STATS_EN: when defined, add outputs served_a, served_b (8 bits each), counting departures per lane, wrapping 255->0, reset to 0.
REQ-026 Without INTERSECTION_STATS_EN, the served_* ports and their counters SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Shared package intersection_pkg SHALL hold the light_t enum (GREEN, YELLOW, RED), the lane FSM state enum and the default QMAX/HEADWAY constants.
REQ-028 Per-lane logic (FSM, headway timer, saturating counter, drop detect) SHALL be a sub-module lane_queue, instantiated twice; the top level holds sensor decode, conflict detection and optional stats.

Verification
REQ-029 Reset with arr_a=1 held, la=RED -> cnt_a=0, ta=0 during reset; after release, cnt_a increments by 1 per cycle and ta=1 one edge later.
REQ-030 cnt_a=3, la switched RED->GREEN, HEADWAY=2, arr_a=0 -> departures on GREEN cycles 2, 4, 6; cnt_a reaches 0 and ta falls after the 3rd departure.
REQ-031 cnt_b=15, lb=RED, arr_b pulse -> cnt_b stays 15, ovf=1 next edge and remains 1 after arr_b drops.
REQ-032 la=GREEN, cnt_a=5, arr_a=1 every cycle with HEADWAY=1 -> cnt_a holds 5.
REQ-033 la=YELLOW, lb=GREEN for one cycle -> conflict=1 next edge, sticky; la=RED, lb=GREEN -> conflict stays 0 after a fresh reset.
REQ-034 With INTERSECTION_STATS_EN, 256 departures on lane A -> served_a wraps to 0; without the macro, the bench compiles with no served_* ports.
